fxp_add_scheduler: RTL and testbench
====================================

Name: fxp_add_scheduler

Overview:
- Round-robin scheduler that shares one sign-magnitude fixed-point adder among NREQ requesters.
- Each requester submits an operand pair over a valid/ready handshake.
- The block arbitrates, sequences the add through a small FSM, and returns the sum tagged with the requester ID over a valid/ready result port.
- Sits between the datapath clients and the fixed-point arithmetic unit.

Parameters:
- N, 16: total word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- Q, 8: fractional bits within the magnitude. Arithmetic does not depend on Q; Q is carried for documentation and benches.
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*N  operand A, flattened; requester i occupies bits [i*N +: N].
- req_b  in  NREQ*N  operand B, flattened in the same way.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  N  sign-magnitude sum.
- res_id  out  IDW  requester that issued the operation.
- res_ovf  out  1  magnitude saturated on this result.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - state=IDLE, rr_ptr=0.
  - res_valid=0, res_data=0, res_id=0, res_ovf=0.
  - Internal operand/ID registers cleared.
  - Any in-flight operation is discarded and its result is never presented.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching cyclically from rr_ptr.
  - req_ready[winner]=1, all other req_ready bits 0; req_ready is combinational from req_valid, state and rr_ptr.
  - On handshake: latch req_a/req_b/ID of the winner, set rr_ptr=(winner+1) mod NREQ, go to EXEC.
  - No valid requester: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - Compute the sum and register res_data/res_ovf/res_id.
  - Set res_valid=1 and go to HOLD.
  - req_ready is all 0.
- HOLD:
  - res_* held stable while res_valid=1 and res_ready=0.
  - When res_ready=1: res_valid drops next cycle and state goes to IDLE.
  - req_ready is all 0, so no accept occurs in the same cycle as the result handshake.
- Latency: request handshake in cycle t gives res_valid=1 in cycle t+2. Minimum spacing between accepts is 3 cycles.
- Operand hold: a requester must keep req_a/req_b stable while req_valid=1 and req_ready=0. A requester may drop req_valid before it is granted (no penalty).
- Arithmetic, with ma/mb = magnitudes (N-1 bits) and sa/sb = sign bits:
  - Same sign: sum=ma+mb computed at N bits.
    - If sum exceeds 2^(N-1)-1: magnitude = all ones (saturate), res_ovf=1.
    - Result sign = sa.
  - Different signs:
    - Magnitude = |ma-mb|; sign = sign of the larger magnitude.
    - If ma==mb: result is +0 (all zero bits).
    - res_ovf=0.
  - Negative-zero input is treated as 0. A result with zero magnitude always carries sign 0.
- busy = (state != IDLE).

Test Plan:
- Basic add, N=16, Q=8: requester 1 sends a=0x0180 (+1.5), b=0x80C0 (-0.75) → res_data=0x00C0, res_id=1, res_ovf=0; res_valid high exactly 2 cycles after the handshake.
- Saturation: a=0x7F00, b=0x0200 → res_data=0x7FFF, res_ovf=1. Same test with a=0xFF00, b=0x8200 → res_data=0xFFFF, res_ovf=1.
- Cancellation and zero: a=0x0100, b=0x8100 → 0x0000. a=0x8000, b=0x8000 → 0x0000, res_ovf=0.
- Round-robin fairness: all four req_valid held high, res_ready=1 → grant order 0,1,2,3,0,1.
  - A new grant every 3 cycles.
  - Never more than one req_ready bit high.
- Backpressure: res_ready held low 5 cycles after res_valid → res_data/res_id/res_ovf stable; req_ready=0 throughout. Raise res_ready → state returns to IDLE and the next grant follows one cycle later.
- Reset mid-operation: assert rst in the EXEC cycle → next cycle res_valid=0, busy=0, rr_ptr=0. A pending request from requester 2 with requester 0 also valid → requester 0 is granted first.

Source files
------------

// File: rtl/fxp_add_scheduler.sv
// Round-robin scheduler sharing one sign-magnitude fixed-point adder among NREQ requesters.
// Latency: request handshake in cycle t gives res_valid in cycle t+2; accepts are at least 3 cycles apart.
// Backpressure: res_* held while res_ready is low; no request is accepted until the result is taken.
module fxp_add_scheduler #(
  parameter int N    = 16,
  parameter int Q    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_ovf,
  output logic              busy
);

  // Reject configurations the ID width or word format cannot represent.
  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || Q > N - 1) begin : g_param_check
    $error("fxp_add_scheduler: invalid parameter combination");
  end

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [IDW-1:0] op_id;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW:0]   idx;

  logic [N-2:0]   ma, mb, mag;
  logic           sa, sb, sgn, ovf;
  logic [N-1:0]   sum;

  // Cyclic search for the first valid requester starting at rr_ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (IDW+1)'(rr_ptr) + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  // Grant is offered only while idle, and only to the search winner.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready = NREQ'(1) << winner;
  end

  // Sign-magnitude add of the latched operands; zero magnitude is always reported as +0.
  always_comb begin
    ma  = op_a[N-2:0];
    mb  = op_b[N-2:0];
    sa  = op_a[N-1];
    sb  = op_b[N-1];
    sum = {1'b0, ma} + {1'b0, mb};
    ovf = 1'b0;
    if (sa == sb) begin
      ovf = sum[N-1];
      mag = ovf ? '1 : sum[N-2:0];
      sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == '0) sgn = 1'b0;
  end

  assign busy = (state != IDLE);

  // Control FSM: accept in IDLE, compute in EXEC, present result in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= req_a[winner*N +: N];
            op_b   <= req_b[winner*N +: N];
            op_id  <= winner;
            rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= {sgn, mag};
          res_ovf   <= ovf;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_add_scheduler.sv
// Directed bench for fxp_add_scheduler: vector table for the arithmetic,
// hand sequences for arbitration order, backpressure and mid-operation reset.
module tb_fxp_add_scheduler;
  localparam int N = 16, Q = 8, NREQ = 4, IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              res_ovf;
  logic              busy;

  int checks = 0;
  int errors = 0;

  fxp_add_scheduler #(.N(N), .Q(Q), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   d;
    logic           o;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) for the FSM to return to IDLE.
  task automatic drain();
    res_ready = 1'b1;
    for (int k = 0; k < 10 && busy; k++) step();
    chk("drain_idle", {31'b0, busy}, 0);
    res_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    req_a[v.id*N +: N] = v.a;
    req_b[v.id*N +: N] = v.b;
    req_valid = NREQ'(1) << v.id;
    res_ready = 1'b0;
    #1;
    chk("op_grant", {28'b0, req_ready}, 32'(1) << v.id);
    step();
    req_valid = '0;
    #1;
    chk("op_exec_valid", {31'b0, res_valid}, 0);
    chk("op_exec_busy", {31'b0, busy}, 1);
    step();
    #1;
    chk("op_valid_t2", {31'b0, res_valid}, 1);
    chk("op_data", {16'b0, res_data}, {16'b0, v.d});
    chk("op_id", {30'b0, res_id}, {30'b0, v.id});
    chk("op_ovf", {31'b0, res_ovf}, {31'b0, v.o});
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    #1;
    chk("op_valid_drop", {31'b0, res_valid}, 0);
    chk("op_idle", {31'b0, busy}, 0);
  endtask

  initial begin
    int g;
    int last;

    vecs[0] = '{2'd1, 16'h0180, 16'h80C0, 16'h00C0, 1'b0};
    vecs[1] = '{2'd0, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1};
    vecs[2] = '{2'd2, 16'hFF00, 16'h8200, 16'hFFFF, 1'b1};
    vecs[3] = '{2'd3, 16'h0100, 16'h8100, 16'h0000, 1'b0};
    vecs[4] = '{2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b0};
    vecs[5] = '{2'd1, 16'h8300, 16'h0100, 16'h8200, 1'b0};
    vecs[6] = '{2'd2, 16'h0100, 16'h0200, 16'h0300, 1'b0};
    vecs[7] = '{2'd3, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0};
    vecs[8] = '{2'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1};
    vecs[9] = '{2'd1, 16'h0005, 16'h800A, 16'h8005, 1'b0};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    rst       = 1'b1;
    step();
    step();
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_res_data", {16'b0, res_data}, 0);
    chk("rst_res_id", {30'b0, res_id}, 0);
    chk("rst_res_ovf", {31'b0, res_ovf}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // All requesters valid, consumer always ready: order 0,1,2,3,0,1 every 3 cycles.
    do_reset();
    req_a = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    req_b = '0;
    req_valid = '1;
    res_ready = 1'b1;
    g = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
      #1;
      chk("rr_onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 1);
      if (req_ready != '0) begin
        chk("rr_order", {28'b0, req_ready}, 32'(1) << (g % 4));
        if (g > 0) chk("rr_spacing", 32'(cyc - last), 3);
        last = cyc;
        g++;
      end
      step();
    end
    chk("rr_grants", 32'(g), 6);
    req_valid = '0;
    drain();

    // Backpressure: result held 5 extra cycles, no grant while holding.
    req_a[3*N +: N] = 16'h0100;
    req_b[3*N +: N] = 16'h0100;
    req_valid = 4'b1000;
    res_ready = 1'b0;
    #1;
    chk("bp_grant", {28'b0, req_ready}, 32'b1000);
    step();
    req_valid = 4'b0001;
    #1;
    chk("bp_exec_ready", {28'b0, req_ready}, 0);
    step();
    #1;
    chk("bp_valid", {31'b0, res_valid}, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk("bp_hold_valid", {31'b0, res_valid}, 1);
      chk("bp_hold_data", {16'b0, res_data}, 32'h0200);
      chk("bp_hold_id", {30'b0, res_id}, 3);
      chk("bp_hold_ovf", {31'b0, res_ovf}, 0);
      chk("bp_hold_ready", {28'b0, req_ready}, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    #1;
    chk("bp_release_valid", {31'b0, res_valid}, 0);
    chk("bp_release_idle", {31'b0, busy}, 0);
    chk("bp_next_grant", {28'b0, req_ready}, 32'b0001);
    step();
    req_valid = '0;
    drain();

    // Reset during EXEC: in-flight result discarded, rr_ptr back to 0.
    req_valid = 4'b0010;
    res_ready = 1'b0;
    #1;
    chk("mr_grant1", {28'b0, req_ready}, 32'b0010);
    step();
    rst = 1'b1;
    req_valid = 4'b0101;
    #1;
    chk("mr_exec_busy", {31'b0, busy}, 1);
    step();
    rst = 1'b0;
    #1;
    chk("mr_valid", {31'b0, res_valid}, 0);
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_grant0", {28'b0, req_ready}, 32'b0001);
    step();
    req_valid = '0;
    #1;
    chk("mr_no_stale", {31'b0, res_valid}, 0);
    step();
    #1;
    chk("mr_res_valid", {31'b0, res_valid}, 1);
    chk("mr_res_id", {30'b0, res_id}, 0);
    chk("mr_res_data", {16'b0, res_data}, 32'h0100);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
